// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit common-anode seven-segment display.
// New values are taken into the display register only at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  dp_mask,
  input  logic        lz_en,
  output logic [7:0]  digit_n,
  output logic [7:0]  seg_n,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam logic [CntW-1:0] LastCnt  = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK_CYC);

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     disp_reg_q, disp_reg_d;
  logic [31:0]     pend_reg_q, pend_reg_d;
  logic            pend_valid_q, pend_valid_d;
  logic [7:0]      digit_n_q, digit_n_d;
  logic [7:0]      seg_n_q, seg_n_d;
  logic            frame_done_q, frame_done_d;

  logic            tick;
  logic            frame_end;
  logic            xfer;
  logic [3:0]      nibble;
  logic            upper_zero;
  logic            blank;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0:    font = 7'b1000000;
      4'h1:    font = 7'b1111001;
      4'h2:    font = 7'b0100100;
      4'h3:    font = 7'b0110000;
      4'h4:    font = 7'b0011001;
      4'h5:    font = 7'b0010010;
      4'h6:    font = 7'b0000010;
      4'h7:    font = 7'b1111000;
      4'h8:    font = 7'b0000000;
      4'h9:    font = 7'b0010000;
      4'hA:    font = 7'b0001000;
      4'hB:    font = 7'b0000011;
      4'hC:    font = 7'b1000110;
      4'hD:    font = 7'b0100001;
      4'hE:    font = 7'b0000110;
      default: font = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tick      = ena && (div_cnt_q == LastCnt);
    frame_end = tick && (idx_q == 3'd7);
    xfer      = frame_end && pend_valid_q;

    div_cnt_d = (!ena || tick) ? '0 : div_cnt_q + 1'b1;
    idx_d     = !ena ? 3'd0 : (tick ? idx_q + 3'd1 : idx_q);

    // A load coinciding with a transfer still lands in pend_reg and stays pending.
    pend_reg_d   = load ? data_in : pend_reg_q;
    pend_valid_d = load ? 1'b1 : (xfer ? 1'b0 : pend_valid_q);
    disp_reg_d   = xfer ? pend_reg_q : disp_reg_q;
    frame_done_d = frame_end;

    nibble     = disp_reg_q[{idx_q, 2'b00} +: 4];
    upper_zero = (disp_reg_q >> {idx_q, 2'b00}) == 32'd0;
    blank      = !ena || (div_cnt_q < BlankCnt) ||
                 (lz_en && (idx_q != 3'd0) && upper_zero);

    digit_n_d = blank ? 8'hFF : ~(8'd1 << idx_q);
    seg_n_d   = blank ? 8'hFF : {~dp_mask[idx_q], font(nibble)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= 3'd0;
      disp_reg_q   <= 32'd0;
      pend_reg_q   <= 32'd0;
      pend_valid_q <= 1'b0;
      digit_n_q    <= 8'hFF;
      seg_n_q      <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      disp_reg_q   <= disp_reg_d;
      pend_reg_q   <= pend_reg_d;
      pend_valid_q <= pend_valid_d;
      digit_n_q    <= digit_n_d;
      seg_n_q      <= seg_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit_n    = digit_n_q;
  assign seg_n      = seg_n_q;
  assign frame_done = frame_done_q;
  assign pending    = pend_valid_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-arithmetic reference model queues the
// expected outputs at each rising edge; a monitor compares them on the falling edge.
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = 8 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        load = 1'b0;
  logic [7:0]  dp_mask = 8'd0;
  logic        lz_en = 1'b0;
  logic [7:0]  digit_n;
  logic [7:0]  seg_n;
  logic        pending;
  logic        frame_done;

  seg_scan_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .data_in   (data_in),
    .load      (load),
    .dp_mask   (dp_mask),
    .lz_en     (lz_en),
    .digit_n   (digit_n),
    .seg_n     (seg_n),
    .pending   (pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dig;
    logic [7:0] seg;
    logic       fd;
    logic       pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  logic [6:0] font_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model state: enabled-cycle count since scan start, plus the two value registers.
  int unsigned m_t = 0;
  logic [31:0] m_disp = 32'd0;
  logic [31:0] m_pend = 32'd0;
  logic        m_pv = 1'b0;

  task automatic model_step();
    exp_t        e;
    int unsigned idx;
    int unsigned ph;
    logic        sup;
    logic [3:0]  nib;
    if (!rst_n) begin
      m_t = 0;
      m_disp = 32'd0;
      m_pend = 32'd0;
      m_pv = 1'b0;
      exp_q.delete();
      return;
    end
    if (!ena) m_t = 0;
    idx = (m_t / SCAN_DIV) % 8;
    ph  = m_t % SCAN_DIV;
    sup = lz_en && (idx != 0) && ((m_disp >> (4 * idx)) == 32'd0);
    e.dig = 8'hFF;
    e.seg = 8'hFF;
    if (ena && (ph >= BLANK_CYC) && !sup) begin
      e.dig[idx] = 1'b0;
      nib = m_disp[4*idx +: 4];
      e.seg = {~dp_mask[idx], font_tbl[nib]};
    end
    e.fd = ena && ((m_t % FRAME) == FRAME - 1);
    if (e.fd && m_pv) begin
      m_disp = m_pend;
      m_pv = 1'b0;
    end
    if (load) begin
      m_pend = data_in;
      m_pv = 1'b1;
    end
    e.pend = m_pv;
    m_t = ena ? m_t + 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_digit_n", digit_n, 8'hFF);
      check("rst_seg_n", seg_n, 8'hFF);
      check("rst_pending", {7'd0, pending}, 8'd0);
      check("rst_frame_done", {7'd0, frame_done}, 8'd0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("digit_n", digit_n, e.dig);
      check("seg_n", seg_n, e.seg);
      check("pending", {7'd0, pending}, {7'd0, e.pend});
      check("frame_done", {7'd0, frame_done}, {7'd0, e.fd});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] v);
    @(negedge clk);
    data_in = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    if (i == budget) begin
      n_checks++;
      $display("FAIL wait_frame_done: no pulse within %0d cycles, expected one", budget);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    cyc(3);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    // Reset and idle with scanning disabled.
    cyc(4);
    #2 rst_n = 1'b1;
    cyc(12);

    // Basic scan.
    ena = 1'b1;
    do_load(32'h76543210);
    cyc(3 * FRAME);

    // Tear-free update mid-frame.
    do_load(32'h11111111);
    wait_fd(2 * FRAME);
    cyc(3 * SCAN_DIV + 1);
    do_load(32'hAAAAAAAA);
    cyc(2 * FRAME + 4);

    // Load landing in the same cycle as the frame transfer.
    wait_fd(2 * FRAME);
    cyc(3);
    do_load(32'h5);
    cyc(25);
    do_load(32'h9);
    cyc(2 * FRAME + 4);

    // Leading-zero suppression.
    lz_en = 1'b1;
    dp_mask = 8'h01;
    do_load(32'h00000120);
    cyc(2 * FRAME + 4);
    do_load(32'h0);
    cyc(2 * FRAME + 4);
    lz_en = 1'b0;
    dp_mask = 8'h00;

    // Disable mid-frame, then re-enable.
    do_load(32'h13572468);
    cyc(FRAME);
    wait_fd(2 * FRAME);
    cyc(5 * SCAN_DIV + 2);
    ena = 1'b0;
    cyc(6);
    ena = 1'b1;
    cyc(FRAME + 8);

    // Reset while a value is pending.
    do_load(32'hDEADBEEF);
    cyc(3);
    reset_pulse();
    cyc(2 * FRAME);

    // Randomized traffic.
    repeat (1500) begin
      @(negedge clk);
      if (ena) begin
        if ($urandom_range(0, 99) == 0) ena = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        ena = 1'b1;
      end
      d = $urandom;
      d = d >> (4 * $urandom_range(0, 7));
      data_in = d;
      load = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) dp_mask = 8'($urandom);
      if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
    end
    load = 1'b0;
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
